// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: filtered PS/2 frame receiver delivering checked scan-code bytes as keyData/keyReady pulses
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyData,
    output logic       keyReady,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [1:0] clk_sync, dat_sync;
    logic filt_clk, filt_prev, sample_ev, sample;
    logic [7:0] filt_cnt, shift, shift_n, data_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic par, par_n, rdy_n, perr_n, ferr_n, filt_flip;
    assign sample_ev = filt_prev & ~filt_clk;
    assign sample = dat_sync[1];
    assign filt_flip = (clk_sync[1] != filt_clk) && (filt_cnt == 8'(FILTER_LEN - 1));
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            filt_clk   <= 1'b1;
            filt_prev  <= 1'b1;
            filt_cnt   <= 8'd0;
            state      <= IDLE;
            tcnt       <= '0;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            par        <= 1'b0;
            keyData    <= 8'h00;
            keyReady   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            filt_prev  <= filt_clk;
            filt_cnt   <= (clk_sync[1] == filt_clk || filt_flip) ? 8'd0 : filt_cnt + 8'd1;
            filt_clk   <= filt_flip ? ~filt_clk : filt_clk;
            state      <= state_n;
            tcnt       <= tcnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par        <= par_n;
            keyData    <= data_n;
            keyReady   <= rdy_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end
    always_comb begin
        state_n   = state;
        tcnt_n    = (state == IDLE || sample_ev) ? '0 : tcnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        data_n    = keyData;
        rdy_n     = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        // a stalled frame is abandoned rather than waiting for edges that may never come
        if (state != IDLE && !sample_ev && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tcnt_n  = '0;
            shift_n = 8'd0;
            ferr_n  = 1'b1;
        end else if (sample_ev) begin
            case (state)
                IDLE: begin
                    bit_cnt_n = sample ? bit_cnt : 3'd0;
                    state_n   = sample ? IDLE : DATA;
                end
                DATA: begin
                    shift_n   = {sample, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = sample;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    ferr_n  = ~sample;
                    rdy_n   = sample & (^{shift, par});
                    perr_n  = sample & ~(^{shift, par});
                    data_n  = rdy_n ? shift : keyData;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed PS/2 frames checked every cycle against a frame-level expectation model
module tb_ps2_scancode_rx;
    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 60;
    logic clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] keyData;
    logic keyReady, parity_err, frame_err;
    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyData(keyData), .keyReady(keyReady), .parity_err(parity_err), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    typedef struct {int kind; logic [7:0] b; int t; int lo; int hi;} exp_t;
    typedef struct {int kind; logic [7:0] d; int a; int b; int c;} lit_t;
    exp_t q[$];
    lit_t lq[$];
    int cyc = 0, rst_cnt = 0, seen_rst = 0, head = 0, lhead = 0;
    int checks = 0, failures = 0, n_rdy = 0, n_perr = 0, n_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    logic prev_rdy = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) rst_cnt <= rst_cnt + 1;
    end
    always @(negedge clk) begin
        int k, el;
        lit_t l;
        if (rst_cnt != seen_rst) begin
            seen_rst = rst_cnt;
            exp_data = 8'h00;
            head = q.size();
            prev_rdy = 1'b0;
        end
        k = keyReady ? 0 : parity_err ? 1 : frame_err ? 2 : -1;
        checks++;
        if (int'(keyReady) + int'(parity_err) + int'(frame_err) > 1) begin
            failures++;
            $display("FAIL excl cyc=%0d got rdy/perr/ferr=%b%b%b required at most one", cyc, keyReady, parity_err, frame_err);
        end
        if (k >= 0) begin
            checks++;
            if (head >= q.size()) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d got kind=%0d required none", cyc, k);
            end else begin
                el = cyc - q[head].t;
                if (k != q[head].kind || el < q[head].lo || el > q[head].hi) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d got kind=%0d lat=%0d required kind=%0d lat=%0d..%0d",
                             cyc, k, el, q[head].kind, q[head].lo, q[head].hi);
                end
                if (q[head].kind == 0) exp_data = q[head].b;
                head++;
            end
        end else if (head < q.size() && cyc - q[head].t > q[head].hi) begin
            checks++;
            failures++;
            $display("FAIL missing_pulse cyc=%0d got none required kind=%0d", cyc, q[head].kind);
            head++;
        end
        checks++;
        if (keyData !== exp_data) begin
            failures++;
            $display("FAIL keyData cyc=%0d got %h required %h", cyc, keyData, exp_data);
        end
        if (keyReady && prev_rdy) begin
            checks++;
            failures++;
            $display("FAIL rdy_width cyc=%0d got two consecutive keyReady required one", cyc);
        end
        prev_rdy = keyReady;
        n_rdy += int'(keyReady);
        n_perr += int'(parity_err);
        n_ferr += int'(frame_err);
        while (lhead < lq.size()) begin
            l = lq[lhead];
            lhead++;
            checks++;
            if (l.kind == 0 && (keyData !== l.d || {keyReady, parity_err, frame_err} !== 3'b000)) begin
                failures++;
                $display("FAIL lit_out cyc=%0d got data=%h flags=%b%b%b required data=%h flags=000",
                         cyc, keyData, keyReady, parity_err, frame_err, l.d);
            end
            if (l.kind == 1 && (n_rdy != l.a || n_perr != l.b || n_ferr != l.c || head != q.size())) begin
                failures++;
                $display("FAIL lit_counts got rdy=%0d perr=%0d ferr=%0d pending=%0d required %0d %0d %0d 0",
                         n_rdy, n_perr, n_ferr, q.size() - head, l.a, l.b, l.c);
            end
        end
    end
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic lit_out(input logic [7:0] d);
        lit_t l;
        l.kind = 0; l.d = d; l.a = 0; l.b = 0; l.c = 0;
        lq.push_back(l);
        wait_n(2);
    endtask
    task automatic glitch();
        ps2_clk = 1'b0;
        wait_n(FL - 2);
        ps2_clk = 1'b1;
    endtask
    task automatic ps2_bit(input logic b, input bit g, output int t);
        ps2_data = b;
        if (g) begin
            wait_n(H / 2);
            glitch();
            wait_n(H / 2 - (FL - 2));
        end else wait_n(H);
        ps2_clk = 1'b0;
        t = cyc;
        wait_n(H);
        ps2_clk = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int g);
        int t;
        exp_t e;
        ps2_bit(1'b0, 1'b0, t);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], g == i, t);
        ps2_bit(p, 1'b0, t);
        e.kind = !s ? 2 : (^{d, p}) ? 0 : 1;
        e.b = d; e.lo = FL; e.hi = FL + 4;
        ps2_data = s;
        wait_n(H);
        ps2_clk = 1'b0;
        e.t = cyc;
        q.push_back(e);
        wait_n(H);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_n(2 * H);
    endtask
    initial begin
        int t;
        exp_t e;
        lit_t l;
        wait_n(3);
        rst = 1'b1;
        lit_out(8'h00);
        glitch();
        wait_n(20);
        glitch();
        wait_n(20);
        send_frame(8'h1D, ~^8'h1D, 1'b1, -1);
        lit_out(8'h1D);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        lit_out(8'hF0);
        send_frame(8'h1D, 1'b1, 1'b1, -1);
        lit_out(8'h1D);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        lit_out(8'h1D);
        send_frame(8'h23, ~^8'h23, 1'b0, -1);
        lit_out(8'h1D);
        ps2_bit(1'b0, 1'b0, t);
        for (int i = 0; i < 4; i++) ps2_bit(t[0] ^ t[0] ^ 1'b1, 1'b0, t);
        e.kind = 2; e.b = 8'h00; e.t = t; e.lo = TO; e.hi = TO + FL + 8;
        q.push_back(e);
        ps2_data = 1'b1;
        wait_n(TO + 100);
        lit_out(8'h1D);
        send_frame(8'h1B, 1'b1, 1'b1, -1);
        lit_out(8'h1B);
        send_frame(8'h1D, 1'b1, 1'b1, 3);
        lit_out(8'h1D);
        ps2_bit(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0, t);
        wait_n(20);
        rst = 1'b0;
        wait_n(1);
        rst = 1'b1;
        lit_out(8'h00);
        ps2_data = 1'b1;
        wait_n(50);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        lit_out(8'h1C);
        l.kind = 1; l.d = 8'h00; l.a = 6; l.b = 1; l.c = 2;
        lq.push_back(l);
        wait_n(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got no completion required finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Receives raw PS/2 keyboard frames on ps2_clk/ps2_data and produces the keyData/keyReady scan-code stream consumed by the object-movement engines. It handles make codes and the 8'hF0 break prefix as ordinary bytes, in arrival order. It sits between the board PS/2 pins and every keyData/keyReady consumer, on the 100 MHz system clock. Parity and framing faults are flagged, and the faulty byte is never delivered.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronized ps2_clk samples required to change the filtered clock level (range 2..255).
TIMEOUT_CYCLES, 25000, clk cycles allowed between filtered falling edges inside a frame before the frame is aborted (250 us at 100 MHz).

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous reset, active-low.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
keyData  output  8  last correctly received byte; held until the next valid byte.
keyReady  output  1  one-cycle pulse; keyData is new and valid in the same cycle.
parity_err  output  1  one-cycle pulse when a frame fails the odd-parity check.
frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout abort.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - Both 2-flop synchronizers load 1; filtered clock and its previous-value register load 1.
  - Filter counter, timeout counter, bit counter and shift register load 0.
  - keyData=8'h00; keyReady, parity_err and frame_err are 0.
  - Reset mid-frame discards the partial byte and produces no pulse.
- Synchronization: ps2_clk and ps2_data each pass through 2 flops. Only the synchronized values are used downstream.
- Glitch filter:
  - The counter increments while sync_clk differs from filt_clk and clears when they are equal.
  - When the count reaches FILTER_LEN-1 and the sample still differs, filt_clk toggles and the counter clears.
- Sample event: filt_clk==0 while the previous filt_clk==1. Data is taken from sync_data in that same cycle.
- FSM. State changes only on a sample event, except for timeout.
  - IDLE: if sample==0 (start bit), clear bit counter and go to DATA. If sample==1, stay in IDLE with no error.
  - DATA: shift LSB-first (shift <= {sample, shift[7:1]}). After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP:
    - sample==1 and ^{shift,parity}==1: keyData<=shift and keyReady=1 in the next cycle.
    - sample==1 and parity wrong: parity_err=1 in the next cycle; keyData is unchanged.
    - sample==0: frame_err=1 in the next cycle; parity is not reported.
    - In every case, return to IDLE.
- Timeout:
  - In DATA, PARITY or STOP, the counter clears on each sample event and otherwise increments.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err for one cycle and discard the partial byte.
  - The counter holds at 0 in IDLE.
- Output pulses are registered, exactly one cycle wide, and mutually exclusive.
  - keyReady never asserts in two consecutive cycles.
  - Consecutive frames produce separate pulses, even for identical bytes.
- Latency: keyReady rises exactly 1 cycle after the sample event of the stop bit. From the raw stop-bit falling edge, this is at most FILTER_LEN+4 cycles.
- The block is receive-only. It never drives ps2_clk or ps2_data and has no host-to-device inhibit.
- No back-pressure: consumers must act on the keyReady cycle. The next byte cannot arrive sooner than about 1 ms later.

Test Plan:
- Valid make code: send 8'h1D (data 1,0,1,1,1,0,0,0 LSB-first, parity 1, stop 1) at a 12.5 kHz PS/2 clock -> one keyReady pulse within FILTER_LEN+4 cycles of the stop edge, keyData=8'h1D, no error pulses.
- Break sequence: send F0 (parity 1), then 1D -> two separate keyReady pulses with keyData=8'hF0 then 8'h1D; keyData holds 8'h1D afterwards.
- Parity error: send 8'h1C with parity 1 (correct parity is 0) -> parity_err pulses once, keyReady stays 0, keyData keeps its prior value.
- Stop error and timeout:
  - Send 8'h23 with stop bit 0 -> frame_err pulses, no keyReady.
  - Separately, stop the PS/2 clock after 4 data bits for more than TIMEOUT_CYCLES -> frame_err pulses once and the FSM returns to IDLE.
  - A following valid 8'h1B is then received correctly.
- Glitch rejection: inject ps2_clk low pulses of FILTER_LEN-2 cycles while idle and mid-frame -> no state change and no bit shifted. A subsequent valid 8'h1D is received correctly.
- Reset mid-frame: assert rst=0 for 1 cycle after 5 data bits, then send a full 8'h1C -> no pulse from the aborted frame; all outputs are 0 immediately after reset; exactly one keyReady pulse with keyData=8'h1C.
